// File: rtl/fused_ofm_writeback_packer_if.sv
// Bus bundle between the fused block, the OFM writeback packer and global BRAM.
// master drives the start/beat/write-ready side; slave is the packer itself.
interface fused_ofm_writeback_packer_if #(
    parameter int IN_W   = 32,
    parameter int WORD_W = 128
);
    logic              start;
    logic [31:0]       base_addr_OFM;
    logic [31:0]       size_OFM;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              in_ready;
    logic [31:0]       wr_addr_global;
    logic [WORD_W-1:0] wr_data_global;
    logic              we_global;
    logic              wr_ready_global;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr_OFM, size_OFM, in_valid, in_data, wr_ready_global,
        input  in_ready, wr_addr_global, wr_data_global, we_global, busy, done
    );

    modport slave (
        input  start, base_addr_OFM, size_OFM, in_valid, in_data, wr_ready_global,
        output in_ready, wr_addr_global, wr_data_global, we_global, busy, done
    );
endinterface

// File: rtl/fused_ofm_writeback_packer.sv
// Packs IN_W-bit layer-2 beats into WORD_W-bit words and writes them to global
// BRAM at consecutive ADDR_STEP-byte addresses through a 2-entry FIFO.
//
// state | meaning
// IDLE  | waiting for start; base/size latched on start
// RUN   | accepting beats until the last one of size_OFM
// DRAIN | no more beats; emptying the FIFO into BRAM
// DONE  | one-cycle completion pulse
module fused_ofm_writeback_packer #(
    parameter int IN_W      = 32,
    parameter int WORD_W    = 128,
    parameter int ADDR_STEP = 16
) (
    input logic clk,
    input logic reset_n,
    fused_ofm_writeback_packer_if.slave bus
);
    localparam int LANES  = WORD_W / IN_W;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, next_state;
    logic [31:0]         base_q;
    logic [31:0]         size_q;
    logic [29:0]         beat_cnt;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   lane_buf;
    logic [WORD_W-1:0]   fifo_mem [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          fifo_count;
    logic [31:0]         word_idx;

    logic                in_ready_i;
    logic                accept, last_beat, push, pop;
    logic [WORD_W-1:0]   beat_word;

    assign accept    = bus.in_valid && in_ready_i;
    // size_OFM is a byte count; the beat count is compared with two zero LSBs
    assign last_beat = accept && ({beat_cnt + 30'd1, 2'b00} == size_q);
    assign push      = accept && ((lane == LANE_W'(LANES - 1)) || last_beat);
    assign pop       = (fifo_count != 2'd0) && bus.wr_ready_global;
    assign beat_word = lane_buf | (WORD_W'(bus.in_data) << (IN_W * int'(lane)));

    assign bus.in_ready       = in_ready_i;
    assign bus.we_global      = (fifo_count != 2'd0);
    assign bus.wr_data_global = fifo_mem[rd_ptr];
    assign bus.wr_addr_global = base_q + word_idx * 32'(ADDR_STEP);

    always_comb begin
        next_state = state;
        in_ready_i = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.size_OFM == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready_i = (fifo_count < 2'd2);
                bus.busy   = 1'b1;
                if (last_beat) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (fifo_count == 2'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            base_q      <= '0;
            size_q      <= '0;
            beat_cnt    <= '0;
            lane        <= '0;
            lane_buf    <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= '0;
            word_idx    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.start) begin
                base_q   <= bus.base_addr_OFM;
                size_q   <= bus.size_OFM;
                beat_cnt <= '0;
                lane     <= '0;
                lane_buf <= '0;
                word_idx <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 30'd1;
                if (push) begin
                    lane     <= '0;
                    lane_buf <= '0;
                end else begin
                    lane     <= lane + 1'b1;
                    lane_buf <= beat_word;
                end
            end
            if (push) begin
                fifo_mem[wr_ptr] <= beat_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                word_idx <= word_idx + 32'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fused_ofm_writeback_packer.sv
// Randomized bench for the OFM writeback packer; expected BRAM words and
// addresses come from a byte-size-driven packing model built per transfer.
module tb_fused_ofm_writeback_packer;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    logic [31:0]  got_a[$];
    logic [127:0] got_d[$];

    fused_ofm_writeback_packer_if #(.IN_W(32), .WORD_W(128)) bus ();

    fused_ofm_writeback_packer #(.IN_W(32), .WORD_W(128), .ADDR_STEP(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.start           = 1'b0;
        bus.base_addr_OFM   = 32'h0;
        bus.size_OFM        = 32'h0;
        bus.in_valid        = 1'b0;
        bus.in_data         = 32'h0;
        bus.wr_ready_global = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.we_global !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.wr_addr_global !== 32'h0 || bus.wr_data_global !== 128'h0) begin
            tests_failed++;
            $display("FAIL %s: rdy=%b we=%b busy=%b done=%b addr=%h data=%h, required all zero",
                     name, bus.in_ready, bus.we_global, bus.busy, bus.done,
                     bus.wr_addr_global, bus.wr_data_global);
        end
    endtask

    // One complete transfer: stimulus, monitoring and comparison against the model.
    task automatic run_xfer(input logic [31:0] base, input int size, input bit seq_data,
                            input int vpct, input int rpct, input int stall,
                            input bit mid_start, input string name);
        int nb, nw, acc, cyc, done_cnt, done_cyc, last_wr;
        bit fin, prev_stall, stalling;
        logic [31:0]  beats[$];
        logic [127:0] exp_w[$];
        logic [127:0] w;
        logic [31:0]  prev_a;
        logic [127:0] prev_d;

        nb = size / 4;
        nw = (size + 15) / 16;
        for (int k = 0; k < nb; k++) beats.push_back(seq_data ? 32'(k) : $urandom);
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int l = 0; l < 4; l++)
                if (4 * i + l < nb) w[32*l +: 32] = beats[4*i+l];
            exp_w.push_back(w);
        end
        got_a.delete();
        got_d.delete();
        acc = 0; cyc = 0; done_cnt = 0; done_cyc = 0; last_wr = -1;
        fin = 0; prev_stall = 0; prev_a = '0; prev_d = '0;

        @(negedge clk);
        bus.start           = 1'b1;
        bus.base_addr_OFM   = base;
        bus.size_OFM        = 32'(size);
        bus.in_valid        = 1'b0;
        bus.wr_ready_global = 1'b0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            bus.start = mid_start && (cyc == 5);
            if (bus.start) begin
                bus.base_addr_OFM = base + 32'h5000;
                bus.size_OFM      = 32'd64;
            end
            if (cyc == 0) begin
                tests_run++;
                if (bus.busy !== (size != 0)) begin
                    tests_failed++;
                    $display("FAIL %s busy_after_start: got %b want %b", name, bus.busy, size != 0);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                tests_run++;
                if (bus.we_global !== 1'b1 || bus.wr_addr_global !== prev_a || bus.wr_data_global !== prev_d) begin
                    tests_failed++;
                    $display("FAIL %s hold_stable: we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                             name, bus.we_global, bus.wr_addr_global, bus.wr_data_global, prev_a, prev_d);
                end
            end
            if (acc == nb) begin
                tests_run++;
                if (bus.in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s ready_after_last: got %b want 0", name, bus.in_ready);
                end
            end
            if (stall > 0 && cyc == stall) begin
                tests_run++;
                if (acc != 8 || bus.in_ready !== 1'b0 || bus.we_global !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s stall_fill: accepted=%0d rdy=%b we=%b, want accepted=8 rdy=0 we=1",
                             name, acc, bus.in_ready, bus.we_global);
                end
            end
            stalling = (cyc < stall);
            bus.in_valid = (acc < nb) && (stalling || ($urandom % 100) < vpct);
            bus.in_data  = bus.in_valid ? beats[acc] : $urandom;
            bus.wr_ready_global = !stalling && (($urandom % 100) < rpct);
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.we_global && bus.wr_ready_global) begin
                got_a.push_back(bus.wr_addr_global);
                got_d.push_back(bus.wr_data_global);
                last_wr = cyc;
            end
            prev_stall = bus.we_global && !bus.wr_ready_global;
            prev_a = bus.wr_addr_global;
            prev_d = bus.wr_data_global;
            if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
            cyc++;
        end
        bus.in_valid        = 1'b0;
        bus.wr_ready_global = 1'b0;
        bus.start           = 1'b0;

        tests_run++;
        if (!fin) begin
            tests_failed++;
            $display("FAIL %s timeout: done never seen in %0d cycles", name, cyc);
        end
        tests_run++;
        if (got_a.size() != nw) begin
            tests_failed++;
            $display("FAIL %s write_count: got %0d want %0d", name, got_a.size(), nw);
        end
        for (int i = 0; i < nw && i < got_a.size(); i++) begin
            tests_run++;
            if (got_a[i] !== base + 32'(16 * i) || got_d[i] !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL %s word%0d: addr=%h data=%h, want addr=%h data=%h",
                         name, i, got_a[i], got_d[i], base + 32'(16 * i), exp_w[i]);
            end
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc <= last_wr) begin
            tests_failed++;
            $display("FAIL %s done_pulse: pulses=%0d at cyc %0d last write cyc %0d, want 1 pulse after last write",
                     name, done_cnt, done_cyc, last_wr);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.we_global !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle_after: busy=%b we=%b want 0 0", name, bus.busy, bus.we_global);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_basic();
        run_xfer(32'h1000, 64, 1'b1, 100, 100, 0, 1'b0, "basic64");
        tests_run++;
        if (got_d.size() < 1 || got_d[0] !== {32'h3, 32'h2, 32'h1, 32'h0}) begin
            tests_failed++;
            $display("FAIL basic64 word0_lanes: got %h want %h",
                     (got_d.size() > 0) ? got_d[0] : 128'h0, {32'h3, 32'h2, 32'h1, 32'h0});
        end
    endtask

    task automatic test_partial();
        run_xfer(32'h2000, 40, 1'b1, 100, 100, 0, 1'b0, "partial40");
        run_xfer(32'hFFFF_FFE0, 52, 1'b0, 70, 60, 0, 1'b0, "partial52_wrap");
    endtask

    task automatic test_backpressure();
        run_xfer(32'h4000, 64, 1'b1, 100, 100, 30, 1'b0, "stall30");
    endtask

    task automatic test_zero_size();
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr_OFM = 32'h8000; bus.size_OFM = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        tests_run++;
        if (bus.done !== 1'b1 || bus.we_global !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_size_done: done=%b we=%b rdy=%b want 1 0 0", bus.done, bus.we_global, bus.in_ready);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.we_global !== 1'b0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_size_after: done=%b busy=%b we=%b rdy=%b want all 0",
                     bus.done, bus.busy, bus.we_global, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        acc = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr_OFM = 32'h6000; bus.size_OFM = 32'd64;
        bus.wr_ready_global = 1'b1;
        for (int c = 0; c < 200 && acc < 6; c++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("reset_mid");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus.we_global !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_quiet: we=%b busy=%b want 0 0", bus.we_global, bus.busy);
            end
        end
        bus.wr_ready_global = 1'b0;
        run_xfer(32'h7000, 32, 1'b0, 80, 80, 0, 1'b0, "after_reset");
    endtask

    task automatic test_ignore();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.in_data = $urandom;
            @(negedge clk);
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.we_global !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_valid: rdy=%b we=%b want 0 0", bus.in_ready, bus.we_global);
            end
        end
        bus.in_valid = 1'b0;
        run_xfer(32'h9000, 128, 1'b0, 50, 30, 0, 1'b1, "start_in_run");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_xfer($urandom, 4 * int'($urandom_range(1, 48)), 1'b0,
                     int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0, 1'b0, "random");
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_zero_size();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
